mc_control: RTL and testbench

Multi-cycle sequencing controller for the MIPS subset datapath (R-type, addi, lw, sw, beq, j). It replaces single-cycle decode with a state machine that steps one shared ALU and one unified instruction/data memory through fetch, decode, execute, memory and write-back. Memory accesses use a req/ready handshake so variable-latency memory stalls the sequence. An optional performance-counter bank can be compiled in.

---
 rtl/mc_control_if.sv | 50 +++++
 rtl/mc_control.sv | 204 ++++++++++++++++++++
 tb/tb_mc_control.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_if.sv
// Control/status bundle between the multi-cycle sequencer and the MIPS datapath + memory.
// Latency: none, this is wiring only.
// Backpressure: mem_req_o is held until mem_ready_i; the master is the controller.
interface mc_control_if #(
  parameter int CNT_W = 32
);
  // datapath / memory status into the controller
  logic [5:0]       Op_i;
  logic             Zero_i;
  logic             mem_ready_i;
  // memory request
  logic             mem_req_o;
  logic             MemRead_o;
  logic             MemWrite_o;
  logic             IorD_o;
  // datapath steering
  logic             IRWrite_o;
  logic             PCWrite_o;
  logic             PCWriteCond_o;
  logic [1:0]       PCSrc_o;
  logic             ALUSrcA_o;
  logic [1:0]       ALUSrcB_o;
  logic [1:0]       ALUOp_o;
  logic             RegDst_o;
  logic             MemtoReg_o;
  logic             RegWrite_o;
  logic             illegal_o;
  // performance counters
  logic [CNT_W-1:0] cycle_cnt_o;
  logic [CNT_W-1:0] instr_cnt_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    input  Op_i, Zero_i, mem_ready_i,
    output mem_req_o, MemRead_o, MemWrite_o, IorD_o,
    output IRWrite_o, PCWrite_o, PCWriteCond_o, PCSrc_o,
    output ALUSrcA_o, ALUSrcB_o, ALUOp_o,
    output RegDst_o, MemtoReg_o, RegWrite_o, illegal_o,
    output cycle_cnt_o, instr_cnt_o, stall_cnt_o
  );

  modport slave (
    output Op_i, Zero_i, mem_ready_i,
    input  mem_req_o, MemRead_o, MemWrite_o, IorD_o,
    input  IRWrite_o, PCWrite_o, PCWriteCond_o, PCSrc_o,
    input  ALUSrcA_o, ALUSrcB_o, ALUOp_o,
    input  RegDst_o, MemtoReg_o, RegWrite_o, illegal_o,
    input  cycle_cnt_o, instr_cnt_o, stall_cnt_o
  );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle MIPS-subset sequencer (fetch/decode/exec/mem/wb) driving one ALU and one unified memory.
// Latency: beq/j 3, R/addi/sw 4, lw 5, illegal 2 cycles, plus one per memory wait cycle.
// Backpressure: FETCH/MEMRD/MEMWR hold request until mem_ready_i; optional counters via CTRL_PERF_CNT_EN.
module mc_control #(
  parameter int CNT_W = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  mc_control_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_MEMRD,
    S_MEMWR, S_RWB, S_IWB, S_LWB, S_BR, S_JMP
  } state_t;

  // Moore control word; fetch_wr marks FETCH so IR/PC load can be qualified by ready,
  // decode marks DECODE so an unsupported opcode can be flagged in that cycle.
  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       fetch_wr;
    logic       decode;
    logic       pcwrite;
    logic       pcwrite_cond;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
  } ctl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
  endfunction

  function automatic state_t next_state(input state_t s, input logic [5:0] op, input logic rdy);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH:  n = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_RTYPE:     n = S_EXEC_R;
          OP_ADDI:      n = S_EXEC_I;
          OP_LW, OP_SW: n = S_ADDR;
          OP_BEQ:       n = S_BR;
          OP_J:         n = S_JMP;
          default:      n = S_FETCH;
        endcase
      end
      S_EXEC_R: n = S_RWB;
      S_EXEC_I: n = S_IWB;
      S_ADDR:   n = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  n = rdy ? S_LWB : S_MEMRD;
      S_MEMWR:  n = rdy ? S_FETCH : S_MEMWR;
      default:  n = S_FETCH;
    endcase
    return n;
  endfunction

  function automatic ctl_t decode_ctl(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req  = 1'b1;
        c.mem_read = 1'b1;
        c.fetch_wr = 1'b1;
        c.alusrcb  = 2'b01;
      end
      S_DECODE: begin
        c.decode  = 1'b1;
        c.alusrcb = 2'b11;
      end
      S_EXEC_R: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      S_EXEC_I, S_ADDR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD: begin
        c.mem_req  = 1'b1;
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWR: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_RWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_IWB: c.regwrite = 1'b1;
      S_LWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BR: begin
        c.alusrca      = 1'b1;
        c.aluop        = 2'b01;
        c.pcwrite_cond = 1'b1;
        c.pcsrc        = 2'b01;
      end
      S_JMP: begin
        c.pcwrite = 1'b1;
        c.pcsrc   = 2'b10;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t r_state;
  ctl_t   r_ctl;
  state_t w_nxt;
  ctl_t   w_ctl;
  logic   w_fetch_go;

  assign w_nxt = next_state(r_state, bus.Op_i, bus.mem_ready_i);

  // State register; the control word is decoded from the next state so outputs come straight from flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_FETCH;
      r_ctl   <= decode_ctl(S_FETCH);
    end else begin
      r_state <= w_nxt;
      r_ctl   <= decode_ctl(w_nxt);
    end
  end

  // Reset kills every output in the same cycle, aborting any in-flight memory request.
  assign w_ctl      = rst_i ? '0 : r_ctl;
  assign w_fetch_go = w_ctl.fetch_wr & bus.mem_ready_i;

  assign bus.mem_req_o     = w_ctl.mem_req;
  assign bus.MemRead_o     = w_ctl.mem_read;
  assign bus.MemWrite_o    = w_ctl.mem_write;
  assign bus.IorD_o        = w_ctl.iord;
  assign bus.IRWrite_o     = w_fetch_go;
  assign bus.PCWrite_o     = w_ctl.pcwrite | w_fetch_go;
  assign bus.PCWriteCond_o = w_ctl.pcwrite_cond;
  assign bus.PCSrc_o       = w_ctl.pcsrc;
  assign bus.ALUSrcA_o     = w_ctl.alusrca;
  assign bus.ALUSrcB_o     = w_ctl.alusrcb;
  assign bus.ALUOp_o       = w_ctl.aluop;
  assign bus.RegDst_o      = w_ctl.regdst;
  assign bus.MemtoReg_o    = w_ctl.memtoreg;
  assign bus.RegWrite_o    = w_ctl.regwrite;
  assign bus.illegal_o     = w_ctl.decode & ~op_legal(bus.Op_i);

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instr_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_retire;
  logic             w_stall;

  // An instruction retires when the sequence returns to FETCH from a completing state (not DECODE).
  assign w_retire = (w_nxt == S_FETCH) &&
                    ((r_state == S_RWB) || (r_state == S_IWB) || (r_state == S_LWB) ||
                     (r_state == S_MEMWR) || (r_state == S_BR) || (r_state == S_JMP));
  assign w_stall  = r_ctl.mem_req & ~bus.mem_ready_i;

  // Free-running wrap-around counters, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (w_retire) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
      if (w_stall)  r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign bus.cycle_cnt_o = rst_i ? '0 : r_cycle_cnt;
  assign bus.instr_cnt_o = rst_i ? '0 : r_instr_cnt;
  assign bus.stall_cnt_o = rst_i ? '0 : r_stall_cnt;
`else
  assign bus.cycle_cnt_o = '0;
  assign bus.instr_cnt_o = '0;
  assign bus.stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: random instruction stream with random memory waits.
// Expected per-cycle control words are built from the per-instruction phase lists.
// Counters are modelled as simple event tallies (zero when the feature is compiled out).
module tb_mc_control;
  localparam int CW = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef logic [17:0] vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_control_if #(.CNT_W(CW)) bus();
  mc_control #(.CNT_W(CW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.master));

  int n_run  = 0;
  int n_fail = 0;
  int m_cyc  = 0;
  int m_ins  = 0;
  int m_stall = 0;

  vec_t E_FW, E_FG, E_DEC, E_ILL, E_EXR, E_EXI, E_MRD, E_MWR, E_RWB, E_IWB, E_LWB, E_BR, E_JMP;

  function automatic vec_t v(input logic req, rd, wr, iord, irw, pcw, pcwc,
                             input logic [1:0] pcsrc, input logic srca,
                             input logic [1:0] srcb, aluop,
                             input logic regdst, m2r, regw, ill);
    return {req, rd, wr, iord, irw, pcw, pcwc, pcsrc, srca, srcb, aluop, regdst, m2r, regw, ill};
  endfunction

  function automatic vec_t observed();
    return {bus.mem_req_o, bus.MemRead_o, bus.MemWrite_o, bus.IorD_o, bus.IRWrite_o,
            bus.PCWrite_o, bus.PCWriteCond_o, bus.PCSrc_o, bus.ALUSrcA_o, bus.ALUSrcB_o,
            bus.ALUOp_o, bus.RegDst_o, bus.MemtoReg_o, bus.RegWrite_o, bus.illegal_o};
  endfunction

  function automatic logic [CW-1:0] ecnt(input int m);
`ifdef CTRL_PERF_CNT_EN
    return CW'(m);
`else
    return (m < 0) ? CW'(1) : '0;
`endif
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op == OP_R || op == OP_ADDI || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_J;
  endfunction

  task automatic chk_vec(input string tag, input vec_t exp);
    vec_t obs;
    obs = observed();
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_counters();
    chk_cnt("cycle_cnt", bus.cycle_cnt_o, ecnt(m_cyc));
    chk_cnt("instr_cnt", bus.instr_cnt_o, ecnt(m_ins));
    chk_cnt("stall_cnt", bus.stall_cnt_o, ecnt(m_stall));
  endtask

  // One non-reset cycle: drive, check, then advance the event tallies.
  task automatic step(input string tag, input vec_t exp, input logic rdy,
                      input logic [5:0] op, input bit stall, input bit retire);
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ready_i = rdy;
    bus.Op_i = op;
    bus.Zero_i = 1'($urandom);
    #1;
    chk_vec(tag, exp);
    chk_counters();
    m_cyc++;
    if (stall) m_stall++;
    if (retire) m_ins++;
  endtask

  task automatic rst_step();
    @(negedge clk);
    rst = 1'b1;
    bus.mem_ready_i = 1'($urandom);
    bus.Op_i = 6'($urandom);
    bus.Zero_i = 1'($urandom);
    #1;
    chk_vec("reset_outputs", '0);
    chk_cnt("reset_cycle_cnt", bus.cycle_cnt_o, '0);
    chk_cnt("reset_instr_cnt", bus.instr_cnt_o, '0);
    chk_cnt("reset_stall_cnt", bus.stall_cnt_o, '0);
    m_cyc = 0;
    m_ins = 0;
    m_stall = 0;
  endtask

  task automatic fetch(input int fst);
    for (int i = 0; i < fst; i++) step("fetch_wait", E_FW, 1'b0, 6'($urandom), 1'b1, 1'b0);
    step("fetch_go", E_FG, 1'b1, 6'($urandom), 1'b0, 1'b0);
  endtask

  // Run one instruction: fst fetch waits, mst memory waits (lw/sw only).
  task automatic run_instr(input logic [5:0] op, input int fst, input int mst);
    fetch(fst);
    if (is_legal(op)) step("decode", E_DEC, 1'($urandom), op, 1'b0, 1'b0);
    else              step("decode_illegal", E_ILL, 1'($urandom), op, 1'b0, 1'b0);
    case (op)
      OP_R: begin
        step("exec_r", E_EXR, 1'($urandom), op, 1'b0, 1'b0);
        step("r_wb", E_RWB, 1'($urandom), op, 1'b0, 1'b1);
      end
      OP_ADDI: begin
        step("exec_i", E_EXI, 1'($urandom), op, 1'b0, 1'b0);
        step("i_wb", E_IWB, 1'($urandom), op, 1'b0, 1'b1);
      end
      OP_LW: begin
        step("addr_lw", E_EXI, 1'($urandom), op, 1'b0, 1'b0);
        for (int i = 0; i < mst; i++) step("memrd_wait", E_MRD, 1'b0, op, 1'b1, 1'b0);
        step("memrd_go", E_MRD, 1'b1, op, 1'b0, 1'b0);
        step("lw_wb", E_LWB, 1'($urandom), op, 1'b0, 1'b1);
      end
      OP_SW: begin
        step("addr_sw", E_EXI, 1'($urandom), op, 1'b0, 1'b0);
        for (int i = 0; i < mst; i++) step("memwr_wait", E_MWR, 1'b0, op, 1'b1, 1'b0);
        step("memwr_go", E_MWR, 1'b1, op, 1'b0, 1'b1);
      end
      OP_BEQ: step("branch", E_BR, 1'($urandom), op, 1'b0, 1'b1);
      OP_J:   step("jump", E_JMP, 1'($urandom), op, 1'b0, 1'b1);
      default: ;
    endcase
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] op;
    case ($urandom_range(0, 6))
      0: op = OP_R;
      1: op = OP_ADDI;
      2: op = OP_LW;
      3: op = OP_SW;
      4: op = OP_BEQ;
      5: op = OP_J;
      default: begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end
    endcase
    return op;
  endfunction

  initial begin
    E_FW  = v(1,1,0,0,0,0,0,2'b00,0,2'b01,2'b00,0,0,0,0);
    E_FG  = v(1,1,0,0,1,1,0,2'b00,0,2'b01,2'b00,0,0,0,0);
    E_DEC = v(0,0,0,0,0,0,0,2'b00,0,2'b11,2'b00,0,0,0,0);
    E_ILL = v(0,0,0,0,0,0,0,2'b00,0,2'b11,2'b00,0,0,0,1);
    E_EXR = v(0,0,0,0,0,0,0,2'b00,1,2'b00,2'b10,0,0,0,0);
    E_EXI = v(0,0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0);
    E_MRD = v(1,1,0,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0);
    E_MWR = v(1,0,1,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0);
    E_RWB = v(0,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,1,0);
    E_IWB = v(0,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,1,0);
    E_LWB = v(0,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,1,1,0);
    E_BR  = v(0,0,0,0,0,0,1,2'b01,1,2'b00,2'b01,0,0,0,0);
    E_JMP = v(0,0,0,0,0,1,0,2'b10,0,2'b00,2'b00,0,0,0,0);

    rst = 1'b1;
    bus.mem_ready_i = 1'b0;
    bus.Op_i = '0;
    bus.Zero_i = 1'b0;
    rst_step();
    rst_step();

    // zero-wait add, then lw with fetch/memory stalls
    run_instr(OP_R, 0, 0);
    run_instr(OP_LW, 2, 3);
    // branch with both Zero_i values (Zero_i is driven randomly each cycle)
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_BEQ, 0, 0);
    // unsupported opcode
    run_instr(6'b111111, 0, 0);
    // store aborted by reset while waiting on memory
    fetch(0);
    step("decode", E_DEC, 1'b1, OP_SW, 1'b0, 1'b0);
    step("addr_sw", E_EXI, 1'b1, OP_SW, 1'b0, 1'b0);
    step("memwr_wait", E_MWR, 1'b0, OP_SW, 1'b1, 1'b0);
    rst_step();
    // zero-wait jumps straight after reset exercise counter wrap
    for (int i = 0; i < 6; i++) run_instr(OP_J, 0, 0);

    // random stream
    for (int i = 0; i < 150; i++) run_instr(rand_op(), $urandom_range(0, 3), $urandom_range(0, 3));
    rst_step();
    run_instr(rand_op(), 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
